// File: rtl/uart_pkg.sv
// Shared types and constants for the UART command-frame decoder.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    OPC  = 3'd1,
    OPA  = 3'd2,
    OPB  = 3'd3,
    CHK  = 3'd4
  } state_e;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_CHK  = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;
  localparam logic [1:0] ERR_OPC  = 2'b11;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/frame_timeout_ctr.sv
// Inter-byte silence counter: clears on clr, counts while en, saturates at the terminal count.
module frame_timeout_ctr #(
  parameter int TIMEOUT_CLKS = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int             CW   = $clog2(TIMEOUT_CLKS);
  localparam logic [CW-1:0]  LAST = CW'(TIMEOUT_CLKS - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  reg_n #(.W(CW)) u_cnt (
    .clk (clk),
    .rst (rst),
    .d   (cnt_d),
    .q   (cnt_q)
  );

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/reg_n.sv
// Generic W-bit register with asynchronous active-high reset.
module reg_n #(
  parameter int             W       = 8,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/uart_frame_decoder.sv
// Assembles SYNC/OPCODE/A/B/CHK frames from UART RX bytes and publishes ALU operands
// only after the XOR checksum matches.
module uart_frame_decoder
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
  parameter int         OP_W         = 4,
  parameter int         TIMEOUT_CLKS = 50000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic [7:0]      op_a,
  output logic [7:0]      op_b,
  output logic [OP_W-1:0] alu_op,
  output logic            frame_valid,
  output logic            frame_err,
  output logic [1:0]      err_code,
  output logic            busy
);

  state_e          state_q;
  state_e          state_d;
  logic [2:0]      state_bits_q;
  logic [7:0]      chk_q, chk_d;
  logic [7:0]      sh_a_q, sh_a_d;
  logic [7:0]      sh_b_q, sh_b_d;
  logic [OP_W-1:0] sh_op_q, sh_op_d;
  logic [7:0]      op_a_q, op_a_d;
  logic [7:0]      op_b_q, op_b_d;
  logic [OP_W-1:0] alu_op_q, alu_op_d;
  logic [1:0]      err_q, err_d;
  logic            fv_q, fv_d;
  logic            fe_q, fe_d;
  logic            busy_q, busy_d;
  logic            tmo_clr, tmo_en, tmo_expired;

  assign state_q = state_e'(state_bits_q);
  assign tmo_clr = rx_valid || (state_q == IDLE);
  assign tmo_en  = (state_q != IDLE) && !rx_valid;

  frame_timeout_ctr #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d  = state_q;
    chk_d    = chk_q;
    sh_a_d   = sh_a_q;
    sh_b_d   = sh_b_q;
    sh_op_d  = sh_op_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    alu_op_d = alu_op_q;
    err_d    = err_q;
    fv_d     = 1'b0;
    fe_d     = 1'b0;

    // A byte arriving on the terminal count wins over the timeout.
    if ((state_q != IDLE) && !rx_valid && tmo_expired) begin
      fe_d    = 1'b1;
      err_d   = ERR_TMO;
      state_d = IDLE;
    end else if (rx_valid) begin
      case (state_q)
        IDLE: begin
          if (rx_data == SYNC_BYTE) begin
            chk_d   = 8'h00;
            state_d = OPC;
          end else begin
            state_d = IDLE;
          end
        end
        OPC: begin
          sh_op_d = rx_data[OP_W-1:0];
          chk_d   = chk_q ^ rx_data;
          if ((rx_data >> OP_W) != 8'h00) begin
            fe_d    = 1'b1;
            err_d   = ERR_OPC;
            state_d = IDLE;
          end else begin
            state_d = OPA;
          end
        end
        OPA: begin
          sh_a_d  = rx_data;
          chk_d   = chk_q ^ rx_data;
          state_d = OPB;
        end
        OPB: begin
          sh_b_d  = rx_data;
          chk_d   = chk_q ^ rx_data;
          state_d = CHK;
        end
        CHK: begin
          if (rx_data == chk_q) begin
            op_a_d   = sh_a_q;
            op_b_d   = sh_b_q;
            alu_op_d = sh_op_q;
            err_d    = ERR_NONE;
            fv_d     = 1'b1;
          end else begin
            fe_d  = 1'b1;
            err_d = ERR_CHK;
          end
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    busy_d = (state_d != IDLE);
  end

  reg_n #(.W(3))    u_state  (.clk(clk), .rst(rst), .d(state_d),  .q(state_bits_q));
  reg_n #(.W(8))    u_chk    (.clk(clk), .rst(rst), .d(chk_d),    .q(chk_q));
  reg_n #(.W(8))    u_sh_a   (.clk(clk), .rst(rst), .d(sh_a_d),   .q(sh_a_q));
  reg_n #(.W(8))    u_sh_b   (.clk(clk), .rst(rst), .d(sh_b_d),   .q(sh_b_q));
  reg_n #(.W(OP_W)) u_sh_op  (.clk(clk), .rst(rst), .d(sh_op_d),  .q(sh_op_q));
  reg_n #(.W(8))    u_op_a   (.clk(clk), .rst(rst), .d(op_a_d),   .q(op_a_q));
  reg_n #(.W(8))    u_op_b   (.clk(clk), .rst(rst), .d(op_b_d),   .q(op_b_q));
  reg_n #(.W(OP_W)) u_alu_op (.clk(clk), .rst(rst), .d(alu_op_d), .q(alu_op_q));
  reg_n #(.W(2))    u_err    (.clk(clk), .rst(rst), .d(err_d),    .q(err_q));
  reg_n #(.W(1))    u_fv     (.clk(clk), .rst(rst), .d(fv_d),     .q(fv_q));
  reg_n #(.W(1))    u_fe     (.clk(clk), .rst(rst), .d(fe_d),     .q(fe_q));
  reg_n #(.W(1))    u_busy   (.clk(clk), .rst(rst), .d(busy_d),   .q(busy_q));

  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign alu_op      = alu_op_q;
  assign frame_valid = fv_q;
  assign frame_err   = fe_q;
  assign err_code    = err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Randomized bench for uart_frame_decoder against a byte-queue reference model.
module tb_uart_frame_decoder;

  localparam int T    = 40;
  localparam int OPW  = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [7:0]     rx_data = 8'h00;
  logic           rx_valid = 1'b0;
  logic [7:0]     op_a, op_b;
  logic [OPW-1:0] alu_op;
  logic           frame_valid, frame_err, busy;
  logic [1:0]     err_code;

  int total = 0;
  int bad   = 0;

  uart_frame_decoder #(
    .SYNC_BYTE    (8'hA5),
    .OP_W         (OPW),
    .TIMEOUT_CLKS (T)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .op_a        (op_a),
    .op_b        (op_b),
    .alu_op      (alu_op),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .err_code    (err_code),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Reference model: bytes of the frame collected so far plus silent-cycle count.
  logic [7:0]     m_buf[$];
  int             m_sil;
  logic [7:0]     m_opa, m_opb;
  logic [OPW-1:0] m_op;
  logic [1:0]     m_err;
  logic           m_fv, m_fe;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_buf.delete();
    m_sil = 0;
    m_opa = 8'h00;
    m_opb = 8'h00;
    m_op  = '0;
    m_err = 2'b00;
    m_fv  = 1'b0;
    m_fe  = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d);
    m_fv = 1'b0;
    m_fe = 1'b0;
    if (v) begin
      m_sil = 0;
      if (m_buf.size() == 0) begin
        if (d == 8'hA5) m_buf.push_back(d);
      end else begin
        m_buf.push_back(d);
        if (m_buf.size() == 2 && d > 8'd15) begin
          m_fe = 1'b1; m_err = 2'b11; m_buf.delete();
        end else if (m_buf.size() == 5) begin
          if (d == (m_buf[1] ^ m_buf[2] ^ m_buf[3])) begin
            m_opa = m_buf[2];
            m_opb = m_buf[3];
            m_op  = m_buf[1][OPW-1:0];
            m_err = 2'b00;
            m_fv  = 1'b1;
          end else begin
            m_fe = 1'b1; m_err = 2'b01;
          end
          m_buf.delete();
        end
      end
    end else if (m_buf.size() > 0) begin
      m_sil++;
      if (m_sil == T) begin
        m_fe = 1'b1; m_err = 2'b10; m_buf.delete(); m_sil = 0;
      end
    end
  endtask

  task automatic check_outputs();
    check("op_a", 32'(op_a), 32'(m_opa));
    check("op_b", 32'(op_b), 32'(m_opb));
    check("alu_op", 32'(alu_op), 32'(m_op));
    check("frame_valid", 32'(frame_valid), 32'(m_fv));
    check("frame_err", 32'(frame_err), 32'(m_fe));
    check("err_code", 32'(err_code), 32'(m_err));
    check("busy", 32'(busy), 32'(m_buf.size() != 0));
  endtask

  task automatic cycle(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    model_step(v, d);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
  endtask

  task automatic send5(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4);
    cycle(1'b1, 8'hA5);
    cycle(1'b1, b1);
    cycle(1'b1, b2);
    cycle(1'b1, b3);
    cycle(1'b1, b4);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #2;
    model_reset();
    check_outputs();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_op_a", 32'(op_a), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic rand_gap();
    int r;
    r = $urandom_range(0, 99);
    if (r < 80)      idle(0);
    else if (r < 95) idle($urandom_range(1, 3));
    else             idle($urandom_range(T - 2, T + 1));
  endtask

  initial begin
    logic [7:0] opc, a, b, c;
    int         sel;
    #1;
    do_reset();

    // Good frame
    send5(8'h03, 8'h12, 8'h34, 8'h25);
    check("good_fv", 32'(frame_valid), 32'd1);
    check("good_op_a", 32'(op_a), 32'h12);
    check("good_op_b", 32'(op_b), 32'h34);
    check("good_alu_op", 32'(alu_op), 32'h3);
    idle(1);
    check("fv_one_cycle", 32'(frame_valid), 32'd0);

    // Bad checksum keeps previous operands
    send5(8'h03, 8'h12, 8'h34, 8'h00);
    check("badchk_fe", 32'(frame_err), 32'd1);
    check("badchk_code", 32'(err_code), 32'h1);
    check("badchk_op_a", 32'(op_a), 32'h12);
    idle(2);

    // Timeout after silence, then byte exactly on the terminal cycle
    cycle(1'b1, 8'hA5);
    cycle(1'b1, 8'h03);
    idle(T);
    check("tmo_fe", 32'(frame_err), 32'd1);
    check("tmo_code", 32'(err_code), 32'h2);
    check("tmo_busy", 32'(busy), 32'd0);
    cycle(1'b1, 8'hA5);
    cycle(1'b1, 8'h03);
    idle(T - 1);
    cycle(1'b1, 8'h12);
    check("term_no_tmo", 32'(busy), 32'd1);
    cycle(1'b1, 8'h34);
    cycle(1'b1, 8'h25);
    check("term_fv", 32'(frame_valid), 32'd1);

    // Bad opcode, then a clean frame
    cycle(1'b1, 8'hA5);
    cycle(1'b1, 8'h13);
    check("badop_fe", 32'(frame_err), 32'd1);
    check("badop_code", 32'(err_code), 32'h3);
    check("badop_busy", 32'(busy), 32'd0);
    send5(8'h05, 8'hAA, 8'h55, 8'hFA);
    check("after_badop_fv", 32'(frame_valid), 32'd1);
    check("after_badop_alu", 32'(alu_op), 32'h5);

    // Noise directly ahead of a frame, all back-to-back
    cycle(1'b1, 8'h00);
    cycle(1'b1, 8'hFF);
    send5(8'h01, 8'h02, 8'h03, 8'h00);
    check("noise_fv", 32'(frame_valid), 32'd1);
    check("noise_op_a", 32'(op_a), 32'h02);
    check("noise_op_b", 32'(op_b), 32'h03);
    check("noise_alu_op", 32'(alu_op), 32'h1);
    // SYNC right on the pulse cycle starts a new frame; A5 inside a frame is data
    send5(8'hA5 & 8'h0F, 8'hA5, 8'hA5, 8'h05);
    check("sync_as_data_fv", 32'(frame_valid), 32'd1);

    // Reset mid-frame
    cycle(1'b1, 8'hA5);
    cycle(1'b1, 8'h03);
    cycle(1'b1, 8'h12);
    do_reset();
    send5(8'h07, 8'h11, 8'h22, 8'h34);
    check("post_rst_fv", 32'(frame_valid), 32'd1);
    check("post_rst_op_b", 32'(op_b), 32'h22);
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 5) begin
        opc = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
        a   = 8'($urandom);
        b   = 8'($urandom);
        c   = opc ^ a ^ b;
        if ($urandom_range(0, 5) == 0) c = c ^ 8'($urandom_range(1, 255));
        cycle(1'b1, 8'hA5); rand_gap();
        cycle(1'b1, opc);   rand_gap();
        cycle(1'b1, a);     rand_gap();
        cycle(1'b1, b);     rand_gap();
        cycle(1'b1, c);     rand_gap();
      end else if (sel <= 8) begin
        cycle(1'b1, 8'($urandom));
      end else begin
        idle($urandom_range(1, 5));
      end
    end
    idle(T + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
